// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for the MAX10 hard ADC: walks the slot list, averages 2^AVG_LOG2 conversions per slot, publishes one result per slot.
// Start to first SOC is 2 cycles (2+TS_SETTLE for the temperature slot), last EOC to result 2 cycles; no backpressure, results are strobed.
module adc_scan_sequencer #(
    parameter int          NUM_SLOTS = 4,
    parameter logic [39:0] CH_LIST   = 40'h0,
    parameter int          AVG_LOG2  = 2,
    parameter logic [4:0]  TS_CH     = 5'd17,
    parameter int          TS_SETTLE = 64,
    parameter int          TIMEOUT   = 4096
) (
    input  logic        pll_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        stop,
    output logic [4:0]  adc_chsel,
    output logic        adc_soc,
    output logic        adc_tsen,
    input  logic        adc_eoc,
    input  logic [11:0] adc_dout,
    output logic        res_valid,
    output logic [2:0]  res_slot,
    output logic [4:0]  res_chan,
    output logic [11:0] res_data,
    output logic        scan_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(TS_SETTLE + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SETTLE,
        CONV,
        ACC,
        PUBLISH
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            eoc_meta;
    logic            eoc_sync;
    logic            eoc_prev;
    logic            eoc_evt;
    logic [2:0]      slot;
    logic [SW-1:0]   sample_cnt;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   settle_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            stop_pend;
    logic [5:0]      ch_base;
    logic [4:0]      cur_ch;
    logic            is_ts;
    logic            last_sample;
    logic            last_slot;
    logic            tmo_hit;

    assign ch_base     = {3'b000, slot} * 6'd5;
    assign cur_ch      = CH_LIST[ch_base +: 5];
    assign is_ts       = (cur_ch == TS_CH);
    assign last_sample = (sample_cnt == SW'((1 << AVG_LOG2) - 1));
    assign last_slot   = (slot == 3'(NUM_SLOTS - 1));
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
    assign eoc_evt     = eoc_sync & ~eoc_prev;
    assign busy        = (state != IDLE);

    always_ff @(posedge pll_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   state_nx = is_ts ? SETTLE : CONV;
            SETTLE:  if (settle_cnt == '0) state_nx = CONV;
            CONV: begin
                // an EOC arriving on the last allowed cycle still counts
                if (eoc_evt)      state_nx = ACC;
                else if (tmo_hit) state_nx = IDLE;
            end
            ACC:     state_nx = last_sample ? PUBLISH : CONV;
            PUBLISH: begin
                if (!last_slot)                    state_nx = SETUP;
                else if (continuous && !stop_pend) state_nx = SETUP;
                else                               state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pll_clk or negedge reset_n) begin
        if (!reset_n) begin
            eoc_meta    <= 1'b0;
            eoc_sync    <= 1'b0;
            eoc_prev    <= 1'b0;
            adc_chsel   <= '0;
            adc_soc     <= 1'b0;
            adc_tsen    <= 1'b0;
            res_valid   <= 1'b0;
            res_slot    <= '0;
            res_chan    <= '0;
            res_data    <= '0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            slot        <= '0;
            sample_cnt  <= '0;
            acc         <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            stop_pend   <= 1'b0;
        end else begin
            eoc_meta  <= adc_eoc;
            eoc_sync  <= eoc_meta;
            eoc_prev  <= eoc_sync;
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            // registered SOC tracks the next state so it drops with the EOC-event edge
            adc_soc   <= (state_nx == CONV);

            if (state_nx == IDLE && state != IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        slot        <= '0;
                        sample_cnt  <= '0;
                        acc         <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                SETUP: begin
                    adc_chsel  <= cur_ch;
                    adc_tsen   <= is_ts;
                    settle_cnt <= CW'(TS_SETTLE - 1);
                    tmo_cnt    <= '0;
                end
                SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                CONV: begin
                    if (eoc_evt) begin
                        acc <= acc + AW'(adc_dout);
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        adc_tsen    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ACC: begin
                    tmo_cnt <= '0;
                    // result registers load here so they appear during PUBLISH
                    if (last_sample) begin
                        res_valid <= 1'b1;
                        res_slot  <= slot;
                        res_chan  <= adc_chsel;
                        res_data  <= acc[AVG_LOG2+11:AVG_LOG2];
                        scan_done <= last_slot;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                PUBLISH: begin
                    acc        <= '0;
                    sample_cnt <= '0;
                    if (last_slot) begin
                        slot <= '0;
                        if (!(continuous && !stop_pend)) adc_tsen <= 1'b0;
                    end else begin
                        slot <= slot + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench: two sequencer instances driven by behavioural ADC models; results checked against sample queues.
module tb_adc_scan_sequencer;

    localparam logic [39:0] CHL_A = {25'd0, 5'd3, 5'd1, 5'd17};
    localparam logic [39:0] CHL_B = {5'd4, 5'd1, 5'd8, 5'd31, 5'd2, 5'd17, 5'd0, 5'd5};
    localparam int AVG_A = 2;
    localparam int TSS_A = 64;
    localparam int TMO_A = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, cont_a, stop_a, start_b, cont_b, stop_b;
    logic [4:0]  chsel_a, chsel_b, rchan_a, rchan_b;
    logic        soc_a, soc_b, tsen_a, tsen_b, eoc_a, eoc_b;
    logic [11:0] dout_a, dout_b, rdata_a, rdata_b;
    logic        rv_a, rv_b, done_a, done_b, busy_a, busy_b, terr_a, terr_b;
    logic [2:0]  rslot_a, rslot_b;

    int n_cmp = 0;
    int n_bad = 0;
    int samp_a[$];
    int chan_a[$];
    int samp_b[$];
    int chan_b[$];
    bit directed = 1'b0;
    bit en_a = 1'b1;
    int ch1_cnt = 0;
    int ch_a[3] = '{17, 1, 3};
    int ch_b[8] = '{5, 0, 17, 2, 31, 8, 1, 4};

    always #5 clk = ~clk;

    adc_scan_sequencer #(.NUM_SLOTS(3), .CH_LIST(CHL_A), .AVG_LOG2(AVG_A), .TS_CH(5'd17),
                         .TS_SETTLE(TSS_A), .TIMEOUT(TMO_A)) u_a (
        .pll_clk(clk), .reset_n(rst_n), .start(start_a), .continuous(cont_a), .stop(stop_a),
        .adc_chsel(chsel_a), .adc_soc(soc_a), .adc_tsen(tsen_a), .adc_eoc(eoc_a), .adc_dout(dout_a),
        .res_valid(rv_a), .res_slot(rslot_a), .res_chan(rchan_a), .res_data(rdata_a),
        .scan_done(done_a), .busy(busy_a), .timeout_err(terr_a));

    adc_scan_sequencer #(.NUM_SLOTS(8), .CH_LIST(CHL_B), .AVG_LOG2(0), .TS_CH(5'd17),
                         .TS_SETTLE(3), .TIMEOUT(64)) u_b (
        .pll_clk(clk), .reset_n(rst_n), .start(start_b), .continuous(cont_b), .stop(stop_b),
        .adc_chsel(chsel_b), .adc_soc(soc_b), .adc_tsen(tsen_b), .adc_eoc(eoc_b), .adc_dout(dout_b),
        .res_valid(rv_b), .res_slot(rslot_b), .res_chan(rchan_b), .res_data(rdata_b),
        .scan_done(done_b), .busy(busy_b), .timeout_err(terr_b));

    // ADC behaviour: answer each SOC after a random delay, log sample and channel
    initial begin : adc_model_a
        eoc_a = 1'b0;
        dout_a = '0;
        forever begin
            @(negedge clk);
            if (soc_a && en_a) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (soc_a && en_a) begin
                    if (directed && chsel_a == 5'd1) begin
                        dout_a = 12'(100 + 2 * ch1_cnt);
                        ch1_cnt++;
                    end else if (directed && chsel_a == 5'd3) begin
                        dout_a = 12'd4095;
                    end else begin
                        dout_a = 12'($urandom_range(0, 4095));
                    end
                    samp_a.push_back(int'(dout_a));
                    chan_a.push_back(int'(chsel_a));
                    eoc_a = 1'b1;
                    for (int i = 0; i < 16 && soc_a; i++) @(negedge clk);
                    eoc_a = 1'b0;
                end
            end
        end
    end

    initial begin : adc_model_b
        eoc_b = 1'b0;
        dout_b = '0;
        forever begin
            @(negedge clk);
            if (soc_b) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (soc_b) begin
                    dout_b = 12'($urandom_range(0, 4095));
                    samp_b.push_back(int'(dout_b));
                    chan_b.push_back(int'(chsel_b));
                    eoc_b = 1'b1;
                    for (int i = 0; i < 16 && soc_b; i++) @(negedge clk);
                    eoc_b = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        samp_a.delete(); chan_a.delete(); samp_b.delete(); chan_b.delete();
    endtask

    // reference: mean of the next 2^AVG_A logged samples; ch < 0 marks a missing or mixed-channel group
    task automatic pop_ref_a(output int avg, output int ch);
        int sum;
        int c;
        sum = 0;
        ch = -1;
        for (int k = 0; k < (1 << AVG_A); k++) begin
            if (samp_a.size() == 0) begin
                ch = -2;
                break;
            end
            sum += samp_a.pop_front();
            c = chan_a.pop_front();
            if (k == 0) ch = c;
            else if (c != ch) ch = -3;
        end
        avg = sum >> AVG_A;
    endtask

    task automatic next_res_a(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (rv_a) got = 1'b1;
        end
    endtask

    task automatic next_res_b(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (rv_b) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy_a, soc_a, tsen_a, rv_a, done_a, terr_a, busy_b, soc_b, tsen_b, rv_b} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0", {busy_a, soc_a, tsen_a, rv_a, done_a, terr_a, busy_b, soc_b, tsen_b, rv_b});
        end
        n_cmp++;
        if ({chsel_a, rdata_a, rslot_a, rchan_a} !== 25'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {chsel_a, rdata_a, rslot_a, rchan_a});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (busy_a !== 1'b0 || soc_a !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy %b soc %b want 0 0", busy_a, soc_a);
        end
    endtask

    task automatic test_ts_and_basic();
        int tsen_n, soc_n, soc_rises, nres, avg, ch;
        bit prev_soc, tsen_drop;
        directed = 1'b1;
        ch1_cnt = 0;
        clear_queues();
        tsen_n = -1; soc_n = -1; soc_rises = 0; nres = 0; prev_soc = 1'b0; tsen_drop = 1'b0;
        start_a = 1'b1;
        for (int n = 1; n <= 3000 && nres < 3; n++) begin
            tick();
            start_a = 1'b0;
            if (n == 1) begin
                n_cmp++;
                if (busy_a !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", busy_a); end
            end
            if (tsen_a && tsen_n < 0) tsen_n = n;
            if (soc_a && soc_n < 0) soc_n = n;
            if (nres == 0 && soc_a && !prev_soc) soc_rises++;
            if (nres == 0 && soc_n > 0 && !tsen_a) tsen_drop = 1'b1;
            prev_soc = soc_a;
            if (rv_a) begin
                pop_ref_a(avg, ch);
                n_cmp++;
                if (rslot_a !== 3'(nres) || rchan_a !== 5'(ch_a[nres]) || ch != ch_a[nres] || done_a !== (nres == 2)) begin
                    n_bad++;
                    $display("FAIL basic_tags: slot %0d chan %0d adc_chan %0d done %b, want slot %0d chan %0d", rslot_a, rchan_a, ch, done_a, nres, ch_a[nres]);
                end
                n_cmp++;
                if (rdata_a !== 12'(avg)) begin n_bad++; $display("FAIL basic_data: got %0d want %0d", rdata_a, avg); end
                if (nres > 0) begin
                    n_cmp++;
                    if (rdata_a !== ((nres == 1) ? 12'd103 : 12'd4095)) begin
                        n_bad++;
                        $display("FAIL basic_plan_value: slot %0d got %0d", nres, rdata_a);
                    end
                end
                nres++;
            end
        end
        n_cmp++;
        if (nres != 3) begin n_bad++; $display("FAIL basic_count: got %0d results want 3", nres); end
        n_cmp++;
        if (soc_n != 2 + TSS_A) begin n_bad++; $display("FAIL ts_start_to_soc: got %0d want %0d", soc_n, 2 + TSS_A); end
        n_cmp++;
        if (soc_n - tsen_n != TSS_A) begin n_bad++; $display("FAIL ts_settle: got %0d want %0d", soc_n - tsen_n, TSS_A); end
        n_cmp++;
        if (soc_rises != 4 || tsen_drop) begin
            n_bad++;
            $display("FAIL ts_hold: socs %0d tsen_dropped %b want 4 0", soc_rises, tsen_drop);
        end
        tick();
        n_cmp++;
        if (busy_a !== 1'b0 || tsen_a !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_end_idle: busy %b tsen %b want 0 0", busy_a, tsen_a);
        end
        directed = 1'b0;
    endtask

    task automatic test_continuous_stop();
        int nres, avg, ch, extra;
        clear_queues();
        nres = 0;
        cont_a = 1'b1;
        start_a = 1'b1;
        for (int n = 1; n <= 20000 && nres < 6; n++) begin
            tick();
            start_a = 1'b0;
            stop_a = 1'b0;
            if (rv_a) begin
                pop_ref_a(avg, ch);
                n_cmp++;
                if (rslot_a !== 3'(nres % 3) || rchan_a !== 5'(ch_a[nres % 3]) || ch != ch_a[nres % 3] || done_a !== (nres % 3 == 2)) begin
                    n_bad++;
                    $display("FAIL cont_tags: idx %0d slot %0d chan %0d adc_chan %0d done %b", nres, rslot_a, rchan_a, ch, done_a);
                end
                n_cmp++;
                if (rdata_a !== 12'(avg)) begin n_bad++; $display("FAIL cont_data: idx %0d got %0d want %0d", nres, rdata_a, avg); end
                if (nres == 3) stop_a = 1'b1;
                nres++;
            end
        end
        n_cmp++;
        if (nres != 6) begin n_bad++; $display("FAIL cont_count: got %0d want 6", nres); end
        tick();
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL cont_stop_idle: busy %b want 0", busy_a); end
        extra = 0;
        repeat (300) begin
            tick();
            if (soc_a || rv_a || busy_a) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL cont_after_stop: activity cycles %0d want 0", extra); end
        cont_a = 1'b0;
    endtask

    task automatic test_timeout();
        int hi, avg, ch;
        bit seen_rv, got;
        en_a = 1'b0;
        clear_queues();
        hi = 0;
        seen_rv = 1'b0;
        start_a = 1'b1;
        for (int n = 1; n <= 6000; n++) begin
            tick();
            start_a = 1'b0;
            if (rv_a) seen_rv = 1'b1;
            if (soc_a) hi++;
            else if (hi > 0) break;
        end
        n_cmp++;
        if (hi != TMO_A) begin n_bad++; $display("FAIL timeout_len: soc high %0d want %0d", hi, TMO_A); end
        n_cmp++;
        if ({terr_a, busy_a, tsen_a, seen_rv} !== 4'b1000) begin
            n_bad++;
            $display("FAIL timeout_flags: terr busy tsen res = %b want 1000", {terr_a, busy_a, tsen_a, seen_rv});
        end
        en_a = 1'b1;
        repeat (5) tick();
        clear_queues();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_cmp++;
        if (terr_a !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got %b want 0", terr_a); end
        for (int r = 0; r < 3; r++) begin
            next_res_a(400, got);
            pop_ref_a(avg, ch);
            n_cmp++;
            if (!got || rslot_a !== 3'(r) || ch != ch_a[r] || rdata_a !== 12'(avg)) begin
                n_bad++;
                $display("FAIL timeout_rescan: r %0d got %b slot %0d data %0d adc_chan %0d want data %0d", r, got, rslot_a, rdata_a, ch, avg);
            end
        end
        tick();
        n_cmp++;
        if (busy_a !== 1'b0 || terr_a !== 1'b0) begin n_bad++; $display("FAIL timeout_end: busy %b terr %b", busy_a, terr_a); end
    endtask

    task automatic test_reset_mid_conv();
        int avg, ch;
        bit got;
        clear_queues();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            tick();
            if (soc_a) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL rst_reach_conv: soc never rose"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({soc_a, tsen_a, busy_a, rv_a, done_a, terr_a, chsel_a, rdata_a, rslot_a, rchan_a} !== 31'b0) begin
            n_bad++;
            $display("FAIL rst_async: got %h want 0", {soc_a, tsen_a, busy_a, rv_a, done_a, terr_a, chsel_a, rdata_a, rslot_a, rchan_a});
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        clear_queues();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int r = 0; r < 3; r++) begin
            next_res_a(400, got);
            pop_ref_a(avg, ch);
            n_cmp++;
            if (!got || rslot_a !== 3'(r) || rchan_a !== 5'(ch_a[r]) || ch != ch_a[r] || rdata_a !== 12'(avg) || done_a !== (r == 2)) begin
                n_bad++;
                $display("FAIL rst_rescan: r %0d got %b slot %0d chan %0d data %0d want data %0d", r, got, rslot_a, rchan_a, rdata_a, avg);
            end
        end
    endtask

    task automatic test_avg0_8slots();
        int exp_d, exp_c;
        bit got;
        clear_queues();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int r = 0; r < 8; r++) begin
            next_res_b(300, got);
            exp_d = (samp_b.size() > 0) ? samp_b.pop_front() : -1;
            exp_c = (chan_b.size() > 0) ? chan_b.pop_front() : -1;
            n_cmp++;
            if (!got || rslot_b !== 3'(r) || rchan_b !== 5'(ch_b[r]) || exp_c != ch_b[r] || done_b !== (r == 7)) begin
                n_bad++;
                $display("FAIL avg0_tags: r %0d got %b slot %0d chan %0d adc_chan %0d done %b", r, got, rslot_b, rchan_b, exp_c, done_b);
            end
            n_cmp++;
            if (rdata_b !== 12'(exp_d)) begin n_bad++; $display("FAIL avg0_data: r %0d got %0d want %0d", r, rdata_b, exp_d); end
            if (r == 1) begin
                start_b = 1'b1;
                tick();
                start_b = 1'b0;
            end
        end
        tick();
        n_cmp++;
        if (busy_b !== 1'b0) begin n_bad++; $display("FAIL avg0_end_idle: busy %b want 0", busy_b); end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; cont_a = 1'b0; stop_a = 1'b0;
        start_b = 1'b0; cont_b = 1'b0; stop_b = 1'b0;
        test_reset();
        test_ts_and_basic();
        test_continuous_stop();
        test_timeout();
        test_reset_mid_conv();
        test_avg0_8slots();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Parametrised conversion sequencer for the MAX10 hard ADC block. It scans a programmable list of up to 8 channel slots, including the on-die temperature sensor, and averages 2^AVG_LOG2 conversions per slot. It publishes one averaged result per slot together with slot and channel tags. The block sits between the ADC primitive wrapper and the display/temperature logic and owns all `chsel`/`soc`/`tsen` sequencing.

## Interface
- NUM_SLOTS, 4: active slots in the scan list, 1..8.
- CH_LIST, 40'h0: packed 5-bit channel numbers; slot k = CH_LIST[5k+4:5k].
- AVG_LOG2, 2: conversions averaged per slot = 2^AVG_LOG2, 0..4.
- TS_CH, 5'd17: channel number that selects the temperature sensor.
- TS_SETTLE, 64: cycles `adc_tsen` is held before the first SOC of a TS slot, ≥1.
- TIMEOUT, 4096: maximum cycles from SOC rise to EOC edge.

Ports:
- pll_clk  in  1  single clock; also drives the ADC primitive.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- continuous  in  1  level; when high, the next scan starts automatically after the last slot.
- stop  in  1  pulse; ends the run after the current slot completes.
- adc_chsel  out  5  channel select to the primitive.
- adc_soc  out  1  start of conversion.
- adc_tsen  out  1  temperature-sensor enable.
- adc_eoc  in  1  end of conversion from the primitive (asynchronous to pll_clk).
- adc_dout  in  12  conversion data.
- res_valid  out  1  one-cycle strobe; result fields valid.
- res_slot  out  3  slot index of the result.
- res_chan  out  5  channel of the result.
- res_data  out  12  averaged result.
- scan_done  out  1  one-cycle strobe, coincident with the last slot's res_valid.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; cleared by an accepted start.

## Operation
- `adc_eoc` passes through a 2-flop synchronizer. A rising edge of the synchronized signal is an EOC event. `adc_dout` is sampled in the EOC-event cycle.
- FSM states: IDLE, SETUP, SETTLE, CONV, ACC, PUBLISH.
- IDLE: a `start` pulse clears `slot`, `sample_cnt`, `acc` and `timeout_err`, then moves to SETUP. `start` while busy is ignored.
- SETUP (1 cycle): `adc_chsel` ← CH_LIST[slot].
  - If that channel equals TS_CH: `adc_tsen` ← 1 and the FSM goes to SETTLE with the counter loaded to TS_SETTLE-1.
  - Otherwise: `adc_tsen` ← 0 and the FSM goes to CONV.
- SETTLE: counts down to 0, then goes to CONV.
- CONV: `adc_soc` = 1 and the timeout counter runs.
  - On an EOC event: `adc_soc` ← 0, `acc` += `adc_dout`, go to ACC.
  - If the counter reaches TIMEOUT with no EOC event: `timeout_err` ← 1, `adc_soc` ← 0, `adc_tsen` ← 0, go to IDLE. No result is published.
- ACC (1 cycle):
  - If `sample_cnt` == 2^AVG_LOG2 − 1: go to PUBLISH.
  - Else: `sample_cnt`++ and go back to CONV. SETTLE is not repeated within a slot.
- PUBLISH (1 cycle):
  - `res_data` = `acc[AVG_LOG2+11:AVG_LOG2]` (truncating shift). `res_valid`, `res_slot` and `res_chan` are updated in the same cycle.
  - `acc` and `sample_cnt` are then cleared.
  - If `slot` == NUM_SLOTS−1: `scan_done` is strobed and `slot` wraps to 0. The FSM goes to SETUP if `continuous` is high and no stop is pending; otherwise it goes to IDLE and `adc_tsen` ← 0.
  - Else: `slot`++ and go to SETUP.
- Widths:
  - `acc` is 12+AVG_LOG2 bits and never overflows.
  - With AVG_LOG2 = 0, `res_data` is the raw sample.
- `adc_chsel` is stable from SETUP until PUBLISH. `adc_chsel` and `adc_tsen` change only in SETUP, PUBLISH or on abort.
- `stop` is latched into `stop_pend` in any state and acted on at the next PUBLISH. `stop_pend` is cleared on entering IDLE. A `start` in the same cycle as PUBLISH→IDLE is ignored.

## Timing
- Reset values: all outputs 0, `adc_chsel` = 0, FSM = IDLE, `timeout_err` = 0, all counters 0. Reset mid-conversion drops `adc_soc` and `adc_tsen` immediately (asynchronous).
- `start` to first `adc_soc`:
  - 2 cycles for a non-TS slot (IDLE→SETUP→CONV).
  - 2+TS_SETTLE cycles for a TS slot.
- EOC pin edge to sample taken: 2-3 cycles (synchronizer plus edge detect).
- EOC event to next `adc_soc` within a slot: 2 cycles (ACC, then CONV).
- Last EOC event of a slot to `res_valid`: 2 cycles.
- `adc_soc` falls no later than 1 cycle after the EOC event. SOC is low for at least 1 cycle between conversions.

## Test plan
- Basic scan: NUM_SLOTS=2, CH_LIST={ch3, ch1}, AVG_LOG2=2; ADC model returns 100, 102, 104, 106 on ch1 and 4095 ×4 on ch3; single `start` → slot 0 gives res_data=103, res_chan=1; slot 1 gives res_data=4095, res_chan=3; `scan_done` with slot 1; then IDLE with busy=0.
- TS slot: CH_LIST slot 0 = 17, TS_SETTLE=64 → `adc_tsen` high exactly 64 cycles before the first `adc_soc`; `adc_tsen` stays high through all 4 conversions; `adc_tsen` is low after the run.
- Continuous with stop: continuous=1, 3 slots; `stop` pulsed during slot 1 of the second scan → results for slots 1 and 2, then `scan_done`, then IDLE; no slot-0 conversion follows.
- Timeout: ADC model never raises EOC, TIMEOUT=4096 → `adc_soc` drops after 4096 cycles; timeout_err=1; no `res_valid`; the next `start` clears timeout_err and the scan completes normally.
- Reset mid-CONV: assert reset_n low while `adc_soc` is high → all outputs 0 in the same cycle; after release, `start` produces a correct full scan.
- AVG_LOG2=0 and NUM_SLOTS=8: 8 results with res_slot 0..7 in order; each res_data equals its single sample.
